lsu_byte_seq: RTL and testbench

LSU_BYTE_SEQ -- requirements
Module: lsu_byte_seq

---
 rtl/lsu_byte_seq.sv | 164 ++++++++++++++++
 tb/tb_lsu_byte_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_byte_seq.sv
// Byte-serial load/store sequencer: splits byte/half/word requests into big-endian byte accesses.
// Optional feature: define LSU_SIGN_EXT_EN to sign-extend byte/half loads when req_signed=1.
module lsu_byte_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [7:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [7:0]  rw_addr,
  output logic [7:0]  w,
  output logic        w_en,
  input  logic [7:0]  r
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR       = 3'd1,
    RD       = 3'd2,
    RD_DRAIN = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t      state;
  logic [1:0]  k;
  logic [1:0]  last_k;
  logic [31:0] sdata;
  logic [23:0] asm_q;
  logic [31:0] aligned;
  logic [31:0] full;
  logic [31:0] load_word;

  // last byte index: byte -> 0, half -> 1, word (and size 3) -> 3
  function automatic logic [1:0] last_of(input logic [1:0] size);
    case (size)
      2'd0:    last_of = 2'd0;
      2'd1:    last_of = 2'd1;
      default: last_of = 2'd3;
    endcase
  endfunction

  // Left-justify store data so the first byte to send sits in bits 31:24.
  function automatic logic [31:0] align_store(input logic [1:0] size, input logic [31:0] data);
    case (size)
      2'd0:    align_store = {data[7:0], 24'd0};
      2'd1:    align_store = {data[15:0], 16'd0};
      default: align_store = data;
    endcase
  endfunction

  assign aligned = align_store(req_size, req_wdata);
  assign full    = {asm_q, r};

`ifdef LSU_SIGN_EXT_EN
  logic sign_q;

  always_comb begin
    load_word = full;
    case (last_k)
      2'd0:    load_word = sign_q ? {{24{full[7]}}, full[7:0]} : {24'd0, full[7:0]};
      2'd1:    load_word = sign_q ? {{16{full[15]}}, full[15:0]} : {16'd0, full[15:0]};
      default: load_word = full;
    endcase
  end
`else
  logic unused_signed;
  assign unused_signed = req_signed;

  always_comb begin
    load_word = full;
    case (last_k)
      2'd0:    load_word = {24'd0, full[7:0]};
      2'd1:    load_word = {16'd0, full[15:0]};
      default: load_word = full;
    endcase
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      k          <= 2'd0;
      last_k     <= 2'd0;
      sdata      <= 32'd0;
      asm_q      <= 24'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      rw_addr    <= 8'd0;
      w          <= 8'd0;
      w_en       <= 1'b0;
`ifdef LSU_SIGN_EXT_EN
      sign_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            k         <= 2'd0;
            last_k    <= last_of(req_size);
            rw_addr   <= req_addr;
            asm_q     <= 24'd0;
`ifdef LSU_SIGN_EXT_EN
            sign_q    <= req_signed;
`endif
            // Outputs are registered, so byte 0 is presented in the first WR/RD cycle.
            if (req_we) begin
              state <= WR;
              w     <= aligned[31:24];
              sdata <= {aligned[23:0], 8'd0};
              w_en  <= 1'b1;
            end else begin
              state <= RD;
            end
          end
        end
        WR: begin
          if (k == last_k) begin
            state      <= DONE;
            w_en       <= 1'b0;
            resp_valid <= 1'b1;
          end else begin
            k       <= k + 2'd1;
            rw_addr <= rw_addr + 8'd1;
            w       <= sdata[31:24];
            sdata   <= {sdata[23:0], 8'd0};
          end
        end
        RD: begin
          // r lags the address by one cycle; k=0 has nothing to capture yet.
          if (k != 2'd0) begin
            asm_q <= {asm_q[15:0], r};
          end
          if (k == last_k) begin
            state <= RD_DRAIN;
          end else begin
            k       <= k + 2'd1;
            rw_addr <= rw_addr + 8'd1;
          end
        end
        RD_DRAIN: begin
          resp_rdata <= load_word;
          resp_valid <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_byte_seq.sv
// Directed scoreboard bench for lsu_byte_seq with a registered byte-wide memory model.
module tb_lsu_byte_seq;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [7:0]  rw_addr;
  logic [7:0]  w;
  logic        w_en;
  logic [7:0]  r;

  logic [7:0]  mem [256];
  logic [31:0] exp_q[$];
  logic [15:0] wr_q[$];
  logic [31:0] last_load;
  logic [31:0] mon_rd;
  logic [15:0] mon_wr;
  int          chk_cnt;
  int          pass_cnt;

  lsu_byte_seq dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .rw_addr    (rw_addr),
    .w          (w),
    .w_en       (w_en),
    .r          (r)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // Memory: registered read, one-cycle latency
  always @(posedge clk) begin
    r <= mem[rw_addr];
    if (w_en) mem[rw_addr] <= w;
  end

  function automatic logic [7:0] init_val(input int i);
    init_val = 8'(i) ^ 8'hA5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (w_en) begin
        if (wr_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL wr_unexpected: got %h@%h expected no write", w, rw_addr);
        end else begin
          mon_wr = wr_q.pop_front();
          chk("wr_byte", {16'd0, rw_addr, w}, {16'd0, mon_wr});
        end
      end
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL resp_unexpected: got %h expected no response", resp_rdata);
        end else begin
          mon_rd = exp_q.pop_front();
          chk("resp_rdata", resp_rdata, mon_rd);
        end
      end
    end
  end

  // Driver: issue one request, queue expectations, measure latency
  task automatic send(input logic we, input logic [1:0] size, input logic sgn,
                      input logic [7:0] addr, input logic [31:0] wdata, input logic [31:0] exp_rd);
    int n;
    int lat;
    int waitc;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    if (we) begin
      for (int k = 0; k < n; k++) wr_q.push_back({addr + 8'(k), wdata[8*(n-1-k) +: 8]});
      exp_q.push_back(last_load);
    end else begin
      exp_q.push_back(exp_rd);
      last_load = exp_rd;
    end
    @(negedge clk);
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    waitc = 0;
    while (!req_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (!req_ready) chk("ready_wait", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (resp_valid) break;
    end
    chk("latency", 32'(lat), 32'(we ? n + 1 : n + 2));
  endtask

  initial begin
    int lat;
    chk_cnt = 0; pass_cnt = 0; last_load = 32'd0;
    for (int i = 0; i < 256; i++) mem[i] = init_val(i);
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = 8'd0; req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_w_en", 32'(w_en), 32'd0);
    chk("rst_rw_addr", 32'(rw_addr), 32'd0);
    chk("rst_w", 32'(w), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);

    send(1'b1, 2'd2, 1'b0, 8'h10, 32'hDEADBEEF, 32'd0);
    send(1'b0, 2'd2, 1'b0, 8'h10, 32'd0, 32'hDEADBEEF);
`ifdef LSU_SIGN_EXT_EN
    send(1'b0, 2'd1, 1'b1, 8'h11, 32'd0, 32'hFFFFADBE);
    send(1'b0, 2'd0, 1'b1, 8'h13, 32'd0, 32'hFFFFFFEF);
`else
    send(1'b0, 2'd1, 1'b1, 8'h11, 32'd0, 32'h0000ADBE);
    send(1'b0, 2'd0, 1'b1, 8'h13, 32'd0, 32'h000000EF);
`endif
    send(1'b0, 2'd1, 1'b0, 8'h12, 32'd0, 32'h0000BEEF);
    send(1'b1, 2'd2, 1'b0, 8'hFE, 32'h01020304, 32'd0);
    send(1'b0, 2'd2, 1'b0, 8'hFE, 32'd0, 32'h01020304);
    send(1'b1, 2'd1, 1'b0, 8'h30, 32'h12345678, 32'd0);
    send(1'b1, 2'd0, 1'b0, 8'h32, 32'hAABBCC9A, 32'd0);
    send(1'b0, 2'd3, 1'b0, 8'h30, 32'd0, 32'h56789A96);

    // Back-to-back: req_valid held through a busy word load
    exp_q.push_back(32'hDEADBEEF);
    exp_q.push_back(32'h00000078);
    last_load = 32'h00000078;
    @(negedge clk);
    req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 8'h10; req_valid = 1'b1;
    chk("b2b_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_size = 2'd0; req_addr = 8'h31;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      chk("b2b_ready_busy", 32'(req_ready), 32'd0);
      if (resp_valid) break;
    end
    chk("b2b_latency1", 32'(lat), 32'd6);
    @(negedge clk);
    chk("b2b_ready_after_done", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (resp_valid) break;
    end
    chk("b2b_latency2", 32'(lat), 32'd3);

    // Reset during the 3rd WR cycle of a word store
    wr_q.push_back({8'h20, 8'hAA});
    wr_q.push_back({8'h21, 8'hBB});
    @(negedge clk);
    req_we = 1'b1; req_size = 2'd2; req_addr = 8'h20; req_wdata = 32'hAABBCCDD; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_w_en", 32'(w_en), 32'd0);
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst_rw_addr", 32'(rw_addr), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_load = 32'd0;
    repeat (3) begin
      @(negedge clk);
      chk("postrst_resp_valid", 32'(resp_valid), 32'd0);
      chk("postrst_req_ready", 32'(req_ready), 32'd1);
    end
    chk("postrst_rdata", resp_rdata, 32'd0);
    chk("mem20", 32'(mem[8'h20]), 32'hAA);
    chk("mem21", 32'(mem[8'h21]), 32'hBB);
    chk("mem22", 32'(mem[8'h22]), 32'(init_val(8'h22)));
    chk("mem23", 32'(mem[8'h23]), 32'(init_val(8'h23)));
    send(1'b0, 2'd2, 1'b0, 8'h20, 32'd0, 32'hAABB8786);

    repeat (4) @(negedge clk);
    chk("resp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("wr_q_empty", 32'(wr_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
